// File: rtl/mac_dot_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mac_dot_engine
//  Description : Two-stage multiply-accumulate dot-product engine. Stage 1
//                registers a full-width product; stage 2 adds it into a
//                saturating or wrapping accumulator and emits one result per
//                frame through a valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_dot_engine #(
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int ACC_WIDTH = 24,
   parameter int SATURATE  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   input  logic                 in_last,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic                 out_overflow
);

   localparam int c_PROD_W = A_WIDTH + B_WIDTH;
   localparam logic [ACC_WIDTH-1:0] c_SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] c_SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [ACC_WIDTH-1:0] c_UMAX = {ACC_WIDTH{1'b1}};

   // State tracks the input side of a frame: IDLE means the next accepted
   // term opens a frame, ACCUM means a frame is open, HOLD means the output
   // was stalled; r_hold_open remembers whether a frame was open on entry.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   r_hold_open;
   logic   w_hold_open_next;
   logic   w_frame_open;
   logic   w_stall;
   logic   w_accept;
   logic   w_mode;
   logic   r_mode;

   logic [c_PROD_W-1:0]  w_prod_u;
   logic [c_PROD_W-1:0]  w_prod_s;
   logic [c_PROD_W-1:0]  w_prod;

   logic                 r_s1_valid;
   logic                 r_s1_last;
   logic                 r_s1_mode;
   logic [c_PROD_W-1:0]  r_s1_prod;

   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic [ACC_WIDTH-1:0] w_ext;
   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_add_ovf;
   logic [ACC_WIDTH-1:0] w_acc_next;

   // A pending, unaccepted result freezes every stage.
   assign w_stall  = out_valid & ~out_ready;
   assign in_ready = ~w_stall;
   assign w_accept = in_valid & in_ready;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_hold_open <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_hold_open <= w_hold_open_next;
      end
   end

   // Next-state logic and frame-mode selection for the incoming term.
   always_comb begin
      w_frame_open     = (r_state == ST_ACCUM) | ((r_state == ST_HOLD) & r_hold_open);
      w_state_next     = w_frame_open ? ST_ACCUM : ST_IDLE;
      w_hold_open_next = r_hold_open;
      if (w_stall) begin
         w_state_next     = ST_HOLD;
         w_hold_open_next = w_frame_open;
      end else if (w_accept) begin
         w_state_next = in_last ? ST_IDLE : ST_ACCUM;
      end
      // The first term of a frame decides the mode for the whole frame.
      w_mode = w_frame_open ? r_mode : signed_mode;
   end

   // Latch the frame mode on every accepted term (stable within a frame).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode <= 1'b0;
      end else if (w_accept) begin
         r_mode <= w_mode;
      end
   end

   // Both products are formed at full width; operands are pre-extended so
   // the low c_PROD_W bits are exact for either interpretation.
   assign w_prod_u = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
   assign w_prod_s = $signed({{B_WIDTH{a[A_WIDTH-1]}}, a}) *
                     $signed({{A_WIDTH{b[B_WIDTH-1]}}, b});
   assign w_prod   = w_mode ? w_prod_s : w_prod_u;

   // Stage 1: register the product with its valid, last and mode bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_mode  <= 1'b0;
         r_s1_prod  <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_prod <= w_prod;
            r_s1_last <= in_last;
            r_s1_mode <= w_mode;
         end
      end
   end

   generate
      if (ACC_WIDTH > c_PROD_W) begin : g_ext_wide
         assign w_ext = {{(ACC_WIDTH-c_PROD_W){r_s1_mode & r_s1_prod[c_PROD_W-1]}}, r_s1_prod};
      end else begin : g_ext_exact
         assign w_ext = r_s1_prod;
      end
   endgenerate

   // One extra sum bit exposes overflow: carry-out when unsigned, sign
   // disagreement of the two top bits when signed.
   always_comb begin
      if (r_s1_mode) begin
         w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + {w_ext[ACC_WIDTH-1], w_ext};
         w_add_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
      end else begin
         w_sum     = {1'b0, r_acc} + {1'b0, w_ext};
         w_add_ovf = w_sum[ACC_WIDTH];
      end
      w_acc_next = w_sum[ACC_WIDTH-1:0];
      if (w_add_ovf && (SATURATE != 0)) begin
         if (r_s1_mode) begin
            w_acc_next = w_sum[ACC_WIDTH] ? c_SMIN : c_SMAX;
         end else begin
            w_acc_next = c_UMAX;
         end
      end
   end

   // Stage 2: accumulate, and on the last term hand the result to the
   // output register while restarting the accumulator at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc        <= '0;
         r_ovf        <= 1'b0;
         out_valid    <= 1'b0;
         out_acc      <= '0;
         out_overflow <= 1'b0;
      end else if (!w_stall) begin
         out_valid <= r_s1_valid & r_s1_last;
         if (r_s1_valid) begin
            if (r_s1_last) begin
               out_acc      <= w_acc_next;
               out_overflow <= r_ovf | w_add_ovf;
               r_acc        <= '0;
               r_ovf        <= 1'b0;
            end else begin
               r_acc <= w_acc_next;
               r_ovf <= r_ovf | w_add_ovf;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_dot_engine
//  Description : Self-checking bench for mac_dot_engine: a 24-bit saturating
//                instance plus 16-bit saturating and wrapping instances, all
//                driven by the same stimulus and checked from a result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_dot_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        in_last;
   logic        signed_mode;
   logic        out_ready;

   logic        in_ready,  in_ready_s16,  in_ready_w16;
   logic        out_valid, out_valid_s16, out_valid_w16;
   logic [23:0] out_acc;
   logic [15:0] out_acc_s16, out_acc_w16;
   logic        out_ovf,   out_ovf_s16,   out_ovf_w16;

   always #5 clk = ~clk;

   mac_dot_engine #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(24), .SATURATE(1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .in_last(in_last), .signed_mode(signed_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_overflow(out_ovf));

   mac_dot_engine #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) u_sat16 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s16),
      .a(a), .b(b), .in_last(in_last), .signed_mode(signed_mode),
      .out_valid(out_valid_s16), .out_ready(out_ready),
      .out_acc(out_acc_s16), .out_overflow(out_ovf_s16));

   mac_dot_engine #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) u_wrap16 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w16),
      .a(a), .b(b), .in_last(in_last), .signed_mode(signed_mode),
      .out_valid(out_valid_w16), .out_ready(out_ready),
      .out_acc(out_acc_w16), .out_overflow(out_ovf_w16));

   typedef struct packed {
      logic [23:0] acc24;
      logic        ov24;
      logic [15:0] acc16s;
      logic        ov16s;
      logic [15:0] acc16w;
      logic        ov16w;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       last;
      logic       smode;
      exp_t       e;
   } vec_t;

   int     n_cmp = 0;
   int     n_bad = 0;
   exp_t   sb_q[$];
   exp_t   mon_e;
   vec_t   tab[$];

   // Reference model state: one running value per instance configuration.
   bit     m_first = 1'b1;
   bit     m_mode  = 1'b0;
   longint m_acc[3];
   bit     m_ovf[3];
   int     m_w[3]   = '{24, 16, 16};
   bit     m_sat[3] = '{1'b1, 1'b1, 1'b0};

   int     w_tmp;
   int     w_stall_cnt;
   int     len;
   int     fmode;
   bit     rnd_done;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_first = 1'b1;
      for (int k = 0; k < 3; k++) begin
         m_acc[k] = 0;
         m_ovf[k] = 1'b0;
      end
   endfunction

   // Integer-range model of one term; returns the frame result when tl=1.
   function automatic exp_t model_term(input logic [7:0] ta, input logic [7:0] tb,
                                       input logic tl, input logic ts);
      longint p, v, lo, hi, md;
      exp_t   r;
      if (m_first) m_mode = ts;
      if (m_mode) p = longint'($signed(ta)) * longint'($signed(tb));
      else        p = longint'(ta) * longint'(tb);
      for (int k = 0; k < 3; k++) begin
         md = longint'(1) << m_w[k];
         if (m_mode) begin
            lo = -(md / 2);
            hi = md / 2 - 1;
         end else begin
            lo = 0;
            hi = md - 1;
         end
         v = m_acc[k] + p;
         if (v < lo || v > hi) begin
            m_ovf[k] = 1'b1;
            if (m_sat[k]) begin
               v = (v < lo) ? lo : hi;
            end else begin
               v = (v - lo) % md;
               if (v < 0) v = v + md;
               v = v + lo;
            end
         end
         m_acc[k] = v;
      end
      r.acc24  = m_acc[0][23:0];
      r.ov24   = m_ovf[0];
      r.acc16s = m_acc[1][15:0];
      r.ov16s  = m_ovf[1];
      r.acc16w = m_acc[2][15:0];
      r.ov16w  = m_ovf[2];
      m_first  = 1'b0;
      if (tl) model_reset();
      return r;
   endfunction

   function automatic vec_t mk(input logic [7:0] ta, input logic [7:0] tb,
                               input logic tl, input logic ts,
                               input logic [23:0] e24, input logic o24,
                               input logic [15:0] e16s, input logic o16s,
                               input logic [15:0] e16w, input logic o16w);
      vec_t v;
      v.a = ta; v.b = tb; v.last = tl; v.smode = ts;
      v.e.acc24  = e24;  v.e.ov24  = o24;
      v.e.acc16s = e16s; v.e.ov16s = o16s;
      v.e.acc16w = e16w; v.e.ov16w = o16w;
      return v;
   endfunction

   // Present one term and hold it until accepted; the expected frame result
   // (table value or model value) is queued at the accepting edge.
   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tl,
                       input logic ts, input bit use_tab, input exp_t te, output int waits);
      bit   done;
      exp_t r;
      waits = 0;
      done  = 1'b0;
      a = ta; b = tb; in_last = tl; signed_mode = ts; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            r = model_term(ta, tb, tl, ts);
            if (tl) sb_q.push_back(use_tab ? te : r);
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 200) begin
               n_cmp++;
               n_bad++;
               $display("FAIL send_timeout: in_ready actual 0 required 1");
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Compare each result as it is handed off downstream.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: actual out_acc %0d required no result", out_acc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("acc24",     out_acc,       mon_e.acc24);
            chk("ovf24",     out_ovf,       mon_e.ov24);
            chk("valid_s16", out_valid_s16, 1);
            chk("acc_s16",   out_acc_s16,   mon_e.acc16s);
            chk("ovf_s16",   out_ovf_s16,   mon_e.ov16s);
            chk("valid_w16", out_valid_w16, 1);
            chk("acc_w16",   out_acc_w16,   mon_e.acc16w);
            chk("ovf_w16",   out_ovf_w16,   mon_e.ov16w);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual not finished required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
      in_last = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
      model_reset();

      // Frames with hand-computed results for all three instances.
      tab.push_back(mk(8'd3,   8'd4,   0, 0, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'd5,   8'd6,   0, 0, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'd255, 8'd255, 1, 0, 24'd65067, 0, 16'd65067, 0, 16'd65067, 0));
      tab.push_back(mk(8'h80,  8'h80,  0, 1, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'hFF,  8'h7F,  1, 1, 24'd16257, 0, 16'd16257, 0, 16'd16257, 0));
      tab.push_back(mk(8'd255, 8'd255, 0, 0, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'd255, 8'd255, 1, 0, 24'd130050, 0, 16'd65535, 1, 16'd64514, 1));
      tab.push_back(mk(8'h80,  8'h7F,  1, 1, 24'd16760960, 0, 16'd49280, 0, 16'd49280, 0));
      tab.push_back(mk(8'd200, 8'd200, 0, 0, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'd255, 8'd2,   1, 1, 24'd40510, 0, 16'd40510, 0, 16'd40510, 0));
      tab.push_back(mk(8'h80,  8'h7F,  0, 1, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'h80,  8'h7F,  0, 1, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'h80,  8'h7F,  0, 1, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'd1,   8'd1,   1, 1, 24'd16728449, 0, 16'd32769, 1, 16'd16769, 1));
      tab.push_back(mk(8'h80,  8'h80,  0, 1, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(8'h80,  8'h80,  1, 1, 24'd32768, 0, 16'd32767, 1, 16'd32768, 1));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_acc",   out_acc,   0);
      chk("rst_out_ovf",   out_ovf,   0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_in_ready_s16", in_ready_s16, 1);
      chk("rst_in_ready_w16", in_ready_w16, 1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < tab.size(); i++) begin
         send(tab[i].a, tab[i].b, tab[i].last, tab[i].smode, 1'b1, tab[i].e, w_tmp);
      end
      repeat (4) @(posedge clk);
      #1;

      // Result becomes visible on the second edge counting the accept edge.
      send(8'd7, 8'd9, 1, 0, 1'b0, '0, w_tmp);
      chk("lat_edge1_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_edge2_valid", out_valid, 1);
      chk("lat_edge2_acc",   out_acc,   63);
      repeat (2) @(posedge clk);
      #1;

      // Output stall for 5 cycles with a product in flight behind it.
      out_ready = 1'b0;
      send(8'd10, 8'd10, 1, 0, 1'b0, '0, w_tmp);
      send(8'd2,  8'd2,  1, 0, 1'b0, '0, w_tmp);
      fork
         send(8'd3, 8'd3, 1, 0, 1'b0, '0, w_stall_cnt);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("stall_in_ready",  in_ready,  0);
               chk("stall_out_valid", out_valid, 1);
               chk("stall_out_acc",   out_acc,   100);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      chk("stall_waits", w_stall_cnt, 5);

      // Back-to-back single-term frames: one accept and one result per cycle.
      for (int i = 0; i < 8; i++) begin
         send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1,
              1'($urandom_range(0, 1)), 1'b0, '0, w_tmp);
         chk("b2b_wait", w_tmp, 0);
      end
      chk("b2b_out_valid", out_valid, 1);

      // Random frames under random output back-pressure.
      rnd_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 12; f++) begin
               len   = $urandom_range(1, 4);
               fmode = $urandom_range(0, 1);
               for (int t = 0; t < len; t++) begin
                  send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       1'(t == len - 1), (t == 0) ? 1'(fmode) : 1'($urandom_range(0, 1)),
                       1'b0, '0, w_tmp);
                  if ($urandom_range(0, 3) == 0) begin
                     @(posedge clk);
                     #1;
                  end
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;

      // Reset in the middle of a frame discards the partial sum.
      send(8'd5, 8'd5, 0, 0, 1'b0, '0, w_tmp);
      send(8'd6, 8'd6, 0, 0, 1'b0, '0, w_tmp);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_acc",   out_acc,   0);
      chk("mid_rst_out_ovf",   out_ovf,   0);
      chk("mid_rst_in_ready",  in_ready,  1);
      sb_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      send(8'd2, 8'd3, 1, 0, 1'b0, '0, w_tmp);
      @(posedge clk);
      #1;
      chk("post_rst_acc", out_acc, 6);

      repeat (5) @(posedge clk);
      #1;
      chk("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
